// File: rtl/fetch_ifid_ctrl.sv
// Fetch stage controller: owns the PC, drives the I-cache request and holds the IF/ID register.
// Responds to hazard stall/flush and branch redirects, including redirects that land while an
// I-cache miss is outstanding.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_ifid_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard_stall,
    input  logic        hazard_flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        icache_stall,
    input  logic [31:0] icache_rdata,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid,
    output logic [6:0]  IF_ID_op,
    output logic [4:0]  IF_ID_rs1,
`ifdef FETCH_PERF_CNT_EN
    output logic [4:0]  IF_ID_rs2,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`else
    output logic [4:0]  IF_ID_rs2
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StMiss, StRedirect} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        bubble_wr;
    logic        fetch_ok;
    logic [31:0] target_aligned;

    assign target_aligned = {branch_target[31:2], 2'b00};

    // State register plus PC, redirect target and IF/ID datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            redirect_pc_q <= 32'h0;
            if_id_pc_q    <= 32'h0;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // Next-state and datapath decisions; a branch always beats a stall or flush
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        bubble_wr     = 1'b0;
        fetch_ok      = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch, StMiss: begin
                if (!icache_stall) begin
                    state_d = StFetch;
                    if (branch_taken) begin
                        pc_d      = target_aligned;
                        bubble_wr = 1'b1;
                    end else if (hazard_stall) begin
                        // word dropped, same pc refetched next cycle
                    end else if (hazard_flush) begin
                        bubble_wr = 1'b1;
                    end else begin
                        fetch_ok      = 1'b1;
                        if_id_pc_d    = pc_q;
                        if_id_inst_d  = icache_rdata;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                    end
                end else if (branch_taken) begin
                    // the outstanding miss must still drain before the new pc is used
                    redirect_pc_d = target_aligned;
                    bubble_wr     = 1'b1;
                    state_d       = StRedirect;
                end else begin
                    state_d = StMiss;
                    // without a stall the old instruction moves on to ID
                    if (!hazard_stall) bubble_wr = 1'b1;
                end
            end
            StRedirect: begin
                if (branch_taken) redirect_pc_d = target_aligned;
                if (!icache_stall) begin
                    pc_d    = branch_taken ? target_aligned : redirect_pc_q;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bubble_wr) begin
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
        end
    end

    // Outputs: request in every non-idle state, address is the held pc
    always_comb begin
        icache_req  = (state_q != StIdle);
        icache_addr = pc_q;
        IF_ID_pc    = if_id_pc_q;
        IF_ID_inst  = if_id_inst_q;
        IF_ID_valid = if_id_valid_q;
        IF_ID_op    = if_id_inst_q[6:0];
        IF_ID_rs1   = if_id_inst_q[19:15];
        IF_ID_rs2   = if_id_inst_q[24:20];
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // Saturating counters of normal accepts and bubble writes
    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (fetch_ok && (perf_fetch_q != 32'hFFFF_FFFF)) perf_fetch_d = perf_fetch_q + 32'd1;
        if (bubble_wr && (perf_bubble_q != 32'hFFFF_FFFF)) perf_bubble_d = perf_bubble_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q  <= 32'h0;
            perf_bubble_q <= 32'h0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_ifid_ctrl.sv
// Directed bench for fetch_ifid_ctrl; define FETCH_PERF_CNT_EN to also check the counters.
module tb_fetch_ifid_ctrl;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hazard_stall, hazard_flush, branch_taken, icache_stall;
    logic [31:0] branch_target, icache_rdata;
    logic        icache_req, IF_ID_valid;
    logic [31:0] icache_addr, IF_ID_pc, IF_ID_inst;
    logic [6:0]  IF_ID_op;
    logic [4:0]  IF_ID_rs1, IF_ID_rs2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Instruction memory model: each word encodes its own address
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[24:0], 7'b0110011};
    endfunction

    assign icache_rdata = word_of(icache_addr);

    fetch_ifid_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hazard_stall  (hazard_stall),
        .hazard_flush  (hazard_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .icache_stall  (icache_stall),
        .icache_rdata  (icache_rdata),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_inst    (IF_ID_inst),
        .IF_ID_valid   (IF_ID_valid),
        .IF_ID_op      (IF_ID_op),
        .IF_ID_rs1     (IF_ID_rs1),
`ifdef FETCH_PERF_CNT_EN
        .IF_ID_rs2     (IF_ID_rs2),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`else
        .IF_ID_rs2     (IF_ID_rs2)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc);
        check_val({tag, " valid"}, {31'b0, IF_ID_valid}, 32'd1);
        check_val({tag, " pc"}, IF_ID_pc, pc);
        check_val({tag, " inst"}, IF_ID_inst, word_of(pc));
    endtask

    task automatic check_bubble(input string tag);
        check_val({tag, " valid"}, {31'b0, IF_ID_valid}, 32'd0);
        check_val({tag, " inst"}, IF_ID_inst, Nop);
    endtask

    initial begin
        rst_n = 1'b0;
        hazard_stall = 1'b0;
        hazard_flush = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        icache_stall = 1'b0;
        #12;
        check_val("rst req", {31'b0, icache_req}, 32'd0);
        check_bubble("rst");
        check_val("rst op", {25'b0, IF_ID_op}, 32'h13);
        check_val("rst rs1", {27'b0, IF_ID_rs1}, 32'd0);
        check_val("rst rs2", {27'b0, IF_ID_rs2}, 32'd0);
        check_val("rst pc", IF_ID_pc, 32'h0);
        check_val("rst addr", icache_addr, 32'h0);

        // Release: first cycle idle, then back-to-back fetches
        rst_n = 1'b1;
        #1;
        check_val("idle req", {31'b0, icache_req}, 32'd0);
        step();
        check_val("fetch req", {31'b0, icache_req}, 32'd1);
        check_val("fetch addr0", icache_addr, 32'h0);
        step();
        check_ifid("seq0", 32'h0);
        check_val("seq0 op", {25'b0, IF_ID_op}, 32'h33);
        check_val("seq0 rs1", {27'b0, IF_ID_rs1}, 32'd0);
        step();
        check_ifid("seq4", 32'h4);
        check_val("seq4 rs2", {27'b0, IF_ID_rs2}, 32'd0);
        step();
        check_ifid("seq8", 32'h8);
        check_val("seq8 addr", icache_addr, 32'hC);

        // Hazard stall for two cycles holds IF/ID and pc
        hazard_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_ifid("stall", 32'h8);
            check_val("stall addr", icache_addr, 32'hC);
        end
        hazard_stall = 1'b0;
        step();
        check_ifid("unstall", 32'hC);

        // Branch during fetch at pc=16, low bits of target dropped
        check_val("pre br addr", icache_addr, 32'h10);
        branch_taken = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        check_bubble("br");
        check_val("br op", {25'b0, IF_ID_op}, 32'h13);
        check_val("br addr", icache_addr, 32'h100);
        // Branch together with hazard stall: branch wins
        hazard_stall = 1'b1;
        branch_target = 32'h0000_0014;
        step();
        hazard_stall = 1'b0;
        branch_taken = 1'b0;
        check_val("br2 addr", icache_addr, 32'h14);

        // Miss at pc=20 for three cycles, redirect arrives in miss cycle 2
        icache_stall = 1'b1;
        step();
        check_val("miss1 addr", icache_addr, 32'h14);
        check_val("miss1 req", {31'b0, icache_req}, 32'd1);
        branch_taken = 1'b1;
        branch_target = 32'h0000_0200;
        step();
        branch_taken = 1'b0;
        check_val("miss2 addr", icache_addr, 32'h14);
        check_bubble("miss2");
        step();
        check_val("miss3 addr", icache_addr, 32'h14);
        icache_stall = 1'b0;
        step();
        check_val("redir addr", icache_addr, 32'h200);
        check_bubble("redir");
        step();
        check_ifid("redir fetch", 32'h200);

        // Flush squashes IF/ID and refetches the same pc
        hazard_flush = 1'b1;
        step();
        hazard_flush = 1'b0;
        check_bubble("flush");
        check_val("flush addr", icache_addr, 32'h204);
        step();
        check_ifid("after flush", 32'h204);

        // PC wrap at the top of the address space
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        check_val("wrap pre", icache_addr, 32'hFFFF_FFFC);
        step();
        check_ifid("wrap top", 32'hFFFF_FFFC);
        check_val("wrap addr", icache_addr, 32'h0);
        step();
        check_ifid("wrap zero", 32'h0);

        // Asynchronous reset during a miss
        icache_stall = 1'b1;
        step();
        check_val("pre rst req", {31'b0, icache_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid rst req", {31'b0, icache_req}, 32'd0);
        check_val("mid rst valid", {31'b0, IF_ID_valid}, 32'd0);
        check_val("mid rst addr", icache_addr, 32'h0);
        icache_stall = 1'b0;
        #3;
        rst_n = 1'b1;

`ifdef FETCH_PERF_CNT_EN
        // Five normal fetches then one flush
        step();
        for (int i = 0; i < 5; i++) step();
        hazard_flush = 1'b1;
        step();
        hazard_flush = 1'b0;
        check_val("perf fetch", perf_fetch_cnt, 32'd5);
        check_val("perf bubble", perf_bubble_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_ifid_ctrl.md
Name: fetch_ifid_ctrl

Overview:
- Fetch-side responder to the hazard unit's stall/flush/redirect requests in the 5-stage RV32 pipeline.
- Owns the PC register, drives the instruction-cache request, and owns the IF/ID pipeline register. Its IF/ID outputs (op, rs1, rs2) feed back into hazard detection.
- Absorbs I-cache miss latency and branch redirects that arrive while a miss is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble encoding written into IF/ID (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hazard_stall  in  1  hold PC and IF/ID.
- hazard_flush  in  1  squash IF/ID contents.
- branch_taken  in  1  redirect fetch to branch_target.
- branch_target  in  32  redirect address; bits [1:0] ignored and forced to 0.
- icache_stall  in  1  cache busy; icache_rdata is not valid while high.
- icache_rdata  in  32  instruction word; valid in any cycle with icache_req=1 and icache_stall=0.
- icache_req  out  1  fetch request.
- icache_addr  out  32  fetch address.
- IF_ID_pc  out  32  PC of the instruction in IF/ID.
- IF_ID_inst  out  32  instruction held in IF/ID.
- IF_ID_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- IF_ID_op  out  7  IF_ID_inst[6:0].
- IF_ID_rs1  out  5  IF_ID_inst[19:15].
- IF_ID_rs2  out  5  IF_ID_inst[24:20].

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE; icache_req=0.
  - IF_ID_inst=NOP_INST, IF_ID_pc=0, IF_ID_valid=0, redirect_pc=0.
  - Applies immediately, including mid-miss.
- States: IDLE, FETCH, MISS, REDIRECT.
- IDLE: icache_req=0; unconditionally goes to FETCH next cycle.
- FETCH and MISS: icache_req=1, icache_addr=pc; the address is held stable for the whole miss.
- A response is accepted in any FETCH/MISS cycle with icache_stall=0. Decision priority on acceptance:
  1. branch_taken: pc<=branch_target; IF_ID<=bubble (NOP_INST, valid=0); fetched word dropped.
  2. hazard_stall: pc and IF_ID hold; word dropped and refetched next cycle.
  3. hazard_flush: IF_ID<=bubble; pc holds; word refetched.
  4. Otherwise: IF_ID<={pc, icache_rdata, valid=1}; pc<=pc+4.
  - After acceptance, state=FETCH.
- FETCH with icache_stall=1 -> MISS.
- During MISS (no acceptance):
  - branch_taken: redirect_pc<=branch_target; IF_ID<=bubble; -> REDIRECT.
  - Else hazard_stall: IF_ID holds.
  - Else: IF_ID<=bubble (the old instruction has advanced).
- REDIRECT:
  - icache_req=1, icache_addr=old pc, held until icache_stall=0.
  - A further branch_taken overwrites redirect_pc (latest wins).
  - IF_ID is held at bubble.
  - On icache_stall=0: data discarded; pc<=redirect_pc; -> FETCH.
  - hazard_stall and hazard_flush have no additional effect.
- Simultaneous branch_taken and hazard_stall: the branch wins.
- PC arithmetic: 32-bit unsigned; pc+4 wraps from 32'hFFFF_FFFC to 0.
- Latency: with no stalls, the word fetched at cycle n appears on IF_ID_* at cycle n+1. Sustained rate is 1 instruction/cycle.
- IF_ID_op/rs1/rs2 are combinational slices of IF_ID_inst. A bubble therefore yields op=7'b0010011, rs1=0, rs2=0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0], which counts accepted responses that took the normal path.
  - Adds perf_bubble_cnt[31:0], which counts cycles in which IF_ID is written with a bubble.
  - Both counters reset to 0 on rst_n, saturate at 32'hFFFF_FFFF, and never wrap.
- Undefined: these ports and all counter logic are absent. The remaining behaviour is identical.

Test Plan:
- Reset release with icache_stall=0 and sequential words -> cycle 1 is IDLE (req=0); IF_ID_pc=0,4,8 follow with valid=1 on consecutive cycles.
- hazard_stall=1 for 2 cycles while IF_ID_pc=8 -> IF_ID_pc stays 8 and icache_addr stays 12; after release IF_ID_pc=12 next cycle.
- branch_taken with branch_target=32'h0000_0103 during FETCH at pc=16 -> IF_ID_valid=0, inst=NOP_INST; next icache_addr=32'h100.
- icache_stall high 3 cycles at pc=20, branch_taken to 32'h200 in miss cycle 2 -> icache_addr stays 20 until the stall drops; then addr=32'h200, and the pc=20 word never reaches IF_ID.
- pc=32'hFFFF_FFFC normal acceptance -> next icache_addr=0. rst_n asserted mid-MISS -> icache_req=0 and IF_ID_valid=0 immediately, pc=RESET_PC.
- With FETCH_PERF_CNT_EN: 5 normal fetches plus 1 flush -> perf_fetch_cnt=5, perf_bubble_cnt=1.
